// File: rtl/stream_accumulator.sv
// stream_accumulator: de-interleaves a round-robin sample stream into CHANNELS
// lanes, reduces FRAME_LEN samples per lane (unsigned sum, signed sum or signed
// max, saturating), then drains one OUT_W result per lane downstream.
// Ports: clk/rst_n (async active-low), clear (sync flush), mode (reduction),
//   in_empty/in_data/in_rden (upstream FIFO, data 1 cycle after rden),
//   out_full/out_wren/out_data (downstream FIFO), frame_done pulse, overflow.
module stream_accumulator #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 32,
  parameter int CHANNELS  = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             in_empty,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_rden,
  input  logic             out_full,
  output logic             out_wren,
  output logic [OUT_W-1:0] out_data,
  output logic             frame_done,
  output logic             overflow
);

  localparam int TOTAL = CHANNELS * FRAME_LEN;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Lane storage is rounded up to a power of two so a CH_W-bit index always fits.
  localparam int LANES = 2 ** CH_W;

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FIRST_C = CNT_W'(CHANNELS);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);

  typedef enum logic {
    S_ACC   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   rcvd;
  logic [CH_W-1:0]    ch;
  logic [CH_W-1:0]    didx;
  logic [1:0]         mode_q;
  logic               rd_pend;
  logic [OUT_W-1:0]   acc [LANES];

  logic               smp_vld;
  logic               last_smp;
  logic               last_wr;
  logic               first_smp;
  logic [OUT_W-1:0]   cur;
  logic [OUT_W-1:0]   x_zext;
  logic [OUT_W-1:0]   x_sext;
  logic [OUT_W:0]     uadd;
  logic [OUT_W:0]     sadd;
  logic [OUT_W-1:0]   new_val;
  logic               sat_hit;

  // A sample is on in_data exactly one cycle after each issued read.
  assign smp_vld   = rd_pend;
  assign last_smp  = smp_vld && (rcvd == LAST_C);
  assign last_wr   = out_wren && (didx == LAST_CH);
  assign first_smp = rcvd < FIRST_C;

  assign in_rden  = rst_n && (state == S_ACC) && !in_empty && (issued < TOTAL_C) && !clear;
  assign out_wren = (state == S_DRAIN) && !out_full;
  assign out_data = acc[didx];

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (last_smp) state_nxt = S_DRAIN;
      S_DRAIN: if (last_wr)  state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // Reduction datapath for the lane currently receiving.
  always_comb begin
    cur     = acc[ch];
    x_zext  = {{(OUT_W-IN_W){1'b0}}, in_data};
    x_sext  = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
    uadd    = {1'b0, cur} + {1'b0, x_zext};
    sadd    = {cur[OUT_W-1], cur} + {x_sext[OUT_W-1], x_sext};
    new_val = cur;
    sat_hit = 1'b0;
    if (first_smp) begin
      new_val = (mode_q == 2'b00) ? x_zext : x_sext;
    end else begin
      case (mode_q)
        2'b00: begin
          if (uadd[OUT_W]) begin
            new_val = {OUT_W{1'b1}};
            sat_hit = 1'b1;
          end else begin
            new_val = uadd[OUT_W-1:0];
          end
        end
        2'b10: begin
          new_val = ($signed(x_sext) > $signed(cur)) ? x_sext : cur;
        end
        default: begin
          // Signed overflow when the extra sign bit disagrees with the MSB.
          if (sadd[OUT_W] != sadd[OUT_W-1]) begin
            new_val = sadd[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
            sat_hit = 1'b1;
          end else begin
            new_val = sadd[OUT_W-1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ACC;
      issued     <= '0;
      rcvd       <= '0;
      ch         <= '0;
      didx       <= '0;
      mode_q     <= '0;
      rd_pend    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (clear) begin
      // Dropping rd_pend discards any sample still in flight from before the flush.
      state      <= S_ACC;
      issued     <= '0;
      rcvd       <= '0;
      ch         <= '0;
      didx       <= '0;
      mode_q     <= '0;
      rd_pend    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      state      <= state_nxt;
      rd_pend    <= in_rden;
      frame_done <= last_wr;
      if (in_rden) begin
        issued <= issued + 1'b1;
        // Mode is frozen at the frame's first read; 11 behaves as signed sum.
        if (issued == '0) mode_q <= (mode == 2'b11) ? 2'b01 : mode;
      end
      if (smp_vld) begin
        acc[ch]  <= new_val;
        overflow <= overflow | sat_hit;
        rcvd     <= rcvd + 1'b1;
        ch       <= (ch == LAST_CH) ? '0 : ch + 1'b1;
      end
      if (out_wren) didx <= didx + 1'b1;
      if (last_wr) begin
        issued <= '0;
        rcvd   <= '0;
        ch     <= '0;
        didx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_accumulator.sv
// Bench for stream_accumulator: upstream FIFO model, randomized frames, and a
// scoreboard whose expected words come from a per-lane arithmetic model.
module tb_stream_accumulator;

  localparam int IN_W  = 8;
  localparam int OUT_W = 9;
  localparam int CH    = 4;
  localparam int FL    = 3;
  localparam int TOTAL = CH * FL;
  localparam int UMAX  = (1 << OUT_W) - 1;
  localparam int SMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int SMIN  = -(1 << (OUT_W - 1));

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             in_empty = 1'b1;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_rden;
  logic             out_full = 1'b0;
  logic             out_wren;
  logic [OUT_W-1:0] out_data;
  logic             frame_done;
  logic             overflow;

  stream_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
    .in_empty(in_empty), .in_data(in_data), .in_rden(in_rden),
    .out_full(out_full), .out_wren(out_wren), .out_data(out_data),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic             exp_ovf[$];
  int               up_q[$];
  int               fb[$];
  logic             model_ovf = 1'b0;
  int fd_cnt = 0, fd_expect = 0;
  int pops_frame = 0, rd_cnt = 0, first_rd = -1, last_rd = -1, cyc = 0;
  bit gaps = 0, bp = 0, full_force = 0, rd_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every downstream write and every frame_done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_wren) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got 0x%0h with no word expected", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done) begin
        fd_cnt++;
        if (exp_ovf.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_done: no frame expected");
        end else begin
          chk("overflow_at_done", 32'(overflow), 32'(exp_ovf.pop_front()));
        end
      end
    end
  end

  // One cycle: sample DUT requests at negedge, react just after the posedge.
  task automatic tick();
    @(negedge clk);
    rd_s = in_rden;
    if (rd_s) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s) begin
      if (up_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_on_empty: read issued with upstream empty");
      end else begin
        in_data = IN_W'(up_q.pop_front());
        pops_frame++;
      end
    end
    in_empty = (up_q.size() == 0) || (gaps && $urandom_range(3) == 0);
    out_full = full_force || (bp && $urandom_range(2) == 0);
  endtask

  // Reference: per lane, fold its samples with saturating integer arithmetic.
  task automatic add_frame(input int m);
    int em;
    em = (m == 3) ? 1 : m;
    for (int c = 0; c < CH; c++) begin
      int s;
      s = 0;
      for (int k = 0; k < FL; k++) begin
        int x, xs;
        x  = fb[k * CH + c];
        xs = (x >= (1 << (IN_W - 1))) ? x - (1 << IN_W) : x;
        if (k == 0) s = (em == 0) ? x : xs;
        else if (em == 0) begin
          s = s + x;
          if (s > UMAX) begin s = UMAX; model_ovf = 1'b1; end
        end else if (em == 1) begin
          s = s + xs;
          if (s > SMAX) begin s = SMAX; model_ovf = 1'b1; end
          else if (s < SMIN) begin s = SMIN; model_ovf = 1'b1; end
        end else if (xs > s) s = xs;
      end
      exp_q.push_back(OUT_W'(s));
    end
    exp_ovf.push_back(model_ovf);
    fd_expect++;
    foreach (fb[i]) up_q.push_back(fb[i]);
    pops_frame = 0; rd_cnt = 0; first_rd = -1; last_rd = -1;
  endtask

  task automatic wait_done(input bit scramble);
    int budget;
    budget = 0;
    while (fd_cnt < fd_expect && budget < 600) begin
      tick();
      budget++;
      if (scramble && pops_frame > 0) mode = 2'($urandom_range(3));
    end
    if (fd_cnt < fd_expect) begin
      checks++; errors++;
      $display("FAIL frame_timeout: done %0d expected %0d", fd_cnt, fd_expect);
      fd_cnt = fd_expect;
    end
  endtask

  task automatic run_frame(input int m, input bit scramble);
    mode = 2'(m);
    add_frame(m);
    wait_done(scramble);
  endtask

  task automatic fill_seq();
    fb.delete();
    for (int i = 1; i <= TOTAL; i++) fb.push_back(i);
  endtask

  task automatic fill_const(input int v);
    fb.delete();
    for (int i = 0; i < TOTAL; i++) fb.push_back(v);
  endtask

  task automatic to_drain_held();
    full_force = 1; out_full = 1'b1;
    while (pops_frame < TOTAL) tick();
    tick();
  endtask

  initial begin
    // Reset state, with upstream claiming data to show in_rden stays low.
    in_empty = 1'b0;
    #23;
    chk("rst_in_rden", 32'(in_rden), 0);
    chk("rst_out_wren", 32'(out_wren), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    in_empty = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Contiguous unsigned frame: 1..12 -> 15,18,21,24 and 12 back-to-back reads.
    fill_seq(); run_frame(0, 0);
    chk("rd_count", 32'(rd_cnt), TOTAL);
    chk("rd_contig", 32'(last_rd - first_rd), TOTAL - 1);

    fill_const(8'hFF); run_frame(1, 0);                 // signed sum of -1s
    fb = '{8'h80, 8'h80, 8'h11, 8'hF0, 8'h7F, 8'h80, 8'h22, 8'hF0,
           8'h01, 8'h80, 8'h05, 8'hFF};
    run_frame(2, 0);                                    // signed max
    fill_const(8'hFF); run_frame(0, 0);                 // unsigned saturation
    tick(); tick();
    chk("ovf_sticky", 32'(overflow), 1);

    // Flush after 3 samples, then a fresh frame.
    fill_seq();
    foreach (fb[i]) up_q.push_back(fb[i]);
    pops_frame = 0;
    while (pops_frame < 3) tick();
    clear = 1'b1; up_q.delete(); in_empty = 1'b1;
    tick();
    clear = 1'b0; model_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    tick(); tick();
    fill_seq(); run_frame(0, 0);

    // Downstream full for 5 cycles at DRAIN entry.
    for (int i = 0; i < TOTAL; i++) fb[i] = $urandom_range(255);
    mode = 2'd1; add_frame(1);
    to_drain_held();
    for (int i = 0; i < 5; i++) begin
      chk("hold_wren", 32'(out_wren), 0);
      chk("hold_rden", 32'(in_rden), 0);
      chk("hold_data", 32'(out_data), 32'(exp_q[0]));
      tick();
    end
    full_force = 0; out_full = 1'b0;
    for (int i = 0; i < CH; i++) tick();
    chk("drain_burst", 32'(exp_q.size()), 0);
    wait_done(0);

    // Reset mid-DRAIN with overflow set, then a clean frame.
    fill_const(8'hFF); mode = 2'd0; add_frame(0);
    to_drain_held();
    rst_n = 1'b0; #1;
    chk("mid_rst_wren", 32'(out_wren), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_rden", 32'(in_rden), 0);
    exp_q.delete(); exp_ovf.delete(); up_q.delete();
    fd_expect--; model_ovf = 1'b0; full_force = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    fill_seq(); run_frame(1, 0);

    // Randomized frames with gaps, backpressure and mid-frame mode changes.
    gaps = 1; bp = 1;
    for (int f = 0; f < 25; f++) begin
      fb.delete();
      for (int i = 0; i < TOTAL; i++) begin
        case ($urandom_range(3))
          0:       fb.push_back(8'hFF);
          1:       fb.push_back($urandom_range(8'h7F, 8'h80));
          default: fb.push_back($urandom_range(255));
        endcase
      end
      run_frame($urandom_range(3), 1);
    end
    gaps = 0; bp = 0;
    tick(); tick();

    chk("frames_done", 32'(fd_cnt), 32'(fd_expect));
    chk("words_left", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
